// File: rtl/cu_pkg.sv
// Shared definitions for the Control Unit dispatcher: execution-FSM indices,
// instruction-class masks applied to the opdecoder code, and state encodings.
package cu_pkg;

  localparam int CU_N_FSM  = 4;
  localparam int CU_CTRL_W = 24;
  localparam int CODE_W    = 32;

  // Execution FSM index order; bit k of every per-FSM vector belongs to FSM k.
  localparam int FSM_ALU         = 0;
  localparam int FSM_LOAD_STORE  = 1;
  localparam int FSM_BRANCH_JUMP = 2;
  localparam int FSM_FLOAT       = 3;

  // A code claims FSM k when any bit under CLASS_MASK_k is set. The masks are
  // disjoint, so a code touching two fields is ambiguous and gets trapped.
  localparam logic [CODE_W-1:0] CLASS_MASK_0 = 32'h0000_00FF;
  localparam logic [CODE_W-1:0] CLASS_MASK_1 = 32'h0000_FF00;
  localparam logic [CODE_W-1:0] CLASS_MASK_2 = 32'h00FF_0000;
  localparam logic [CODE_W-1:0] CLASS_MASK_3 = 32'hFF00_0000;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_FETCH      = 3'd1,
    ST_FETCH_WAIT = 3'd2,
    ST_DECODE     = 3'd3,
    ST_START      = 3'd4,
    ST_RUN        = 3'd5,
    ST_RETIRE     = 3'd6,
    ST_TRAP       = 3'd7
  } cu_state_e;

  // Class mask of FSM k; FSMs beyond the four defined classes never match.
  function automatic logic [CODE_W-1:0] class_mask(input int k);
    case (k)
      FSM_ALU:         return CLASS_MASK_0;
      FSM_LOAD_STORE:  return CLASS_MASK_1;
      FSM_BRANCH_JUMP: return CLASS_MASK_2;
      FSM_FLOAT:       return CLASS_MASK_3;
      default:         return '0;
    endcase
  endfunction

endpackage

// File: rtl/fsm_class_decode.sv
// Maps the opdecoder code onto the execution-FSM select vector and flags
// whether exactly one FSM was claimed.
module fsm_class_decode
  import cu_pkg::*;
#(
  parameter int N_FSM = CU_N_FSM
) (
  input  logic [CODE_W-1:0] code_i,
  output logic [N_FSM-1:0]  onehot_o,
  output logic              valid_o
);

  logic [N_FSM-1:0] minus_one;

  // Per-FSM class hit, then a zero/one-hot test on the hit vector.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first, so no path leaves it unassigned and no latch is inferred.
    onehot_o = '0;
    for (int k = 0; k < N_FSM; k++) begin
      onehot_o[k] = |(code_i & class_mask(k));
    end
    minus_one = onehot_o - N_FSM'(1);
    valid_o   = (onehot_o != '0) && ((onehot_o & minus_one) == '0);
  end

endmodule

// File: rtl/fsm_dispatcher.sv
// Top-level Control Unit sequencer: fetches an instruction, hands the
// datapath to one execution FSM until it reports done, then retires.
// Also detects illegal instruction classes and runaway FSMs.
module fsm_dispatcher
  import cu_pkg::*;
#(
  parameter int N_FSM   = CU_N_FSM,
  parameter int CTRL_W  = CU_CTRL_W,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    run,
  input  logic                    mem_done,
  input  logic [CODE_W-1:0]       code,
  input  logic [N_FSM-1:0]        fsm_done,
  input  logic [N_FSM*CTRL_W-1:0] fsm_ctrl,
  output logic                    fetch_mem_start,
  output logic                    load_ir,
  output logic [N_FSM-1:0]        fsm_start,
  output logic [CTRL_W-1:0]       ctrl_out,
  output logic                    busy,
  output logic                    insn_retired,
  output logic                    illegal,
  output logic                    timeout
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  cu_state_e          state_q, state_d;
  logic [N_FSM-1:0]   sel_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               fetch_q, route_q, busy_q, retired_q;
  logic               illegal_q, timeout_q;
  logic [N_FSM-1:0]   start_q;

  logic [N_FSM-1:0]   dec_onehot;
  logic               dec_valid;
  logic               done_hit;
  logic               wdog_expired;
  logic [CTRL_W-1:0]  ctrl_mux;

  fsm_class_decode #(
    .N_FSM (N_FSM)
  ) u_class_decode (
    .code_i   (code),
    .onehot_o (dec_onehot),
    .valid_o  (dec_valid)
  );

  // Only the selected FSM may end the instruction; others' done is ignored.
  assign done_hit     = |(fsm_done & sel_q);
  assign wdog_expired = (cnt_q == CNT_LAST);

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:       if (run) state_d = ST_FETCH;
      ST_FETCH:      state_d = ST_FETCH_WAIT;
      ST_FETCH_WAIT: if (mem_done) state_d = ST_DECODE;
      ST_DECODE:     state_d = dec_valid ? ST_START : ST_TRAP;
      ST_START:      state_d = ST_RUN;
      ST_RUN: begin
        // Done takes priority over a watchdog expiring in the same cycle.
        if (done_hit)          state_d = ST_RETIRE;
        else if (wdog_expired) state_d = ST_TRAP;
      end
      ST_RETIRE:     state_d = run ? ST_FETCH : ST_IDLE;
      ST_TRAP:       state_d = ST_TRAP;
      default:       state_d = ST_IDLE;
    endcase
  end

  // State, class select, watchdog, sticky flags and Moore outputs decoded
  // from the next state so each strobe lines up with its own state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      cnt_q     <= '0;
      fetch_q   <= 1'b0;
      start_q   <= '0;
      route_q   <= 1'b0;
      busy_q    <= 1'b0;
      retired_q <= 1'b0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
      state_q   <= state_d;
      fetch_q   <= (state_d == ST_FETCH);
      start_q   <= (state_d == ST_START) ? dec_onehot : '0;
      route_q   <= (state_d == ST_START) || (state_d == ST_RUN);
      busy_q    <= (state_d != ST_IDLE) && (state_d != ST_TRAP);
      retired_q <= (state_d == ST_RETIRE);

      if (state_q == ST_DECODE) begin
        sel_q <= dec_onehot;
        if (!dec_valid) illegal_q <= 1'b1;
      end

      if (state_q == ST_START) begin
        cnt_q <= '0;
      end else if (state_q == ST_RUN && !done_hit) begin
        if (wdog_expired) timeout_q <= 1'b1;
        else              cnt_q     <= cnt_q + CNT_W'(1);
      end
    end
  end

  // AND-OR mux of the control bundles over the one-hot select.
  always_comb begin
    ctrl_mux = '0;
    for (int k = 0; k < N_FSM; k++) begin
      ctrl_mux = ctrl_mux | (fsm_ctrl[k*CTRL_W +: CTRL_W] & {CTRL_W{sel_q[k]}});
    end
  end

  // route_q is cleared by the asynchronous reset, so the datapath loses its
  // control bundle the moment reset rises.
  assign ctrl_out        = ctrl_mux & {CTRL_W{route_q}};
  assign load_ir         = (state_q == ST_FETCH_WAIT) && mem_done;
  assign fetch_mem_start = fetch_q;
  assign fsm_start       = start_q;
  assign busy            = busy_q;
  assign insn_retired    = retired_q;
  assign illegal         = illegal_q;
  assign timeout         = timeout_q;

endmodule

// File: tb/tb_fsm_dispatcher.sv
// Directed bench for fsm_dispatcher with a short watchdog (TIMEOUT=8).
module tb_fsm_dispatcher;

  localparam int N  = 4;
  localparam int W  = 24;
  localparam int TO = 8;

  localparam logic [W-1:0]  B0 = 24'h111111;
  localparam logic [W-1:0]  B1 = 24'h222222;
  localparam logic [W-1:0]  B2 = 24'hABCDEF;
  localparam logic [W-1:0]  B3 = 24'h333333;
  localparam logic [31:0] ALU_CODE = 32'h0000_0001;
  localparam logic [31:0] BR_CODE  = 32'h0001_0000;
  localparam logic [31:0] BAD2     = 32'h0000_0101;

  logic           clk = 1'b0;
  logic           reset, run, mem_done;
  logic [31:0]    code;
  logic [N-1:0]   fsm_done;
  logic [N*W-1:0] fsm_ctrl;
  logic           fetch_mem_start, load_ir, busy, insn_retired, illegal, timeout;
  logic [N-1:0]   fsm_start;
  logic [W-1:0]   ctrl_out;

  int n_tests = 0;
  int n_fail  = 0;
  int n_start = 0;
  int n_ret   = 0;
  int n_fetch = 0;

  fsm_dispatcher #(.N_FSM(N), .CTRL_W(W), .TIMEOUT(TO)) dut (
    .clk             (clk),
    .reset           (reset),
    .run             (run),
    .mem_done        (mem_done),
    .code            (code),
    .fsm_done        (fsm_done),
    .fsm_ctrl        (fsm_ctrl),
    .fetch_mem_start (fetch_mem_start),
    .load_ir         (load_ir),
    .fsm_start       (fsm_start),
    .ctrl_out        (ctrl_out),
    .busy            (busy),
    .insn_retired    (insn_retired),
    .illegal         (illegal),
    .timeout         (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge and tally strobes seen there.
  task automatic tick();
    @(negedge clk);
    if (fsm_start != '0) n_start++;
    if (insn_retired)    n_ret++;
    if (fetch_mem_start) n_fetch++;
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; mem_done = 1'b0; fsm_done = '0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  // From IDLE or RETIRE: fetch, wait `w` extra cycles for memory, end in DECODE.
  task automatic issue(input logic [31:0] c, input int w);
    code = c; run = 1'b1;
    tick();
    check("fetch_strobe", fetch_mem_start, 1);
    check("fetch_busy", busy, 1);
    tick();
    check("fetch_one_cycle", fetch_mem_start, 0);
    for (int i = 0; i < w; i++) begin
      check("no_load_ir_early", load_ir, 0);
      tick();
    end
    mem_done = 1'b1;
    #1;
    check("load_ir", load_ir, 1);
    tick();
    mem_done = 1'b0;
    #1;
    check("load_ir_decode", load_ir, 0);
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; mem_done = 1'b0; code = '0; fsm_done = '0;
    fsm_ctrl = {B3, B2, B1, B0};
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_ctrl", ctrl_out, 0);
    check("rst_fetch", fetch_mem_start, 0);
    check("rst_start", fsm_start, 0);
    check("rst_flags", {illegal, timeout, insn_retired, load_ir}, 0);
    reset = 1'b0;
    tick();
    check("idle_busy", busy, 0);

    // Branch instruction, memory answers 2 cycles after FETCH, done 5 after START.
    n_start = 0; n_ret = 0;
    issue(BR_CODE, 1);
    tick();
    check("br_start", fsm_start, 4'b0100);
    check("br_start_ctrl", ctrl_out, B2);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("br_run_ctrl", ctrl_out, B2);
      check("br_run_nostart", fsm_start, 0);
      if (i == 2) begin
        fsm_done = 4'b0001;
        fsm_ctrl[W +: W] = 24'hFFFFFF;
      end
      if (i == 3) begin
        fsm_done = '0;
        fsm_ctrl[W +: W] = B1;
      end
      if (i == 5) fsm_done = 4'b0100;
    end
    tick();
    fsm_done = '0;
    check("br_retire", insn_retired, 1);
    check("br_retire_ctrl", ctrl_out, 0);
    check("br_start_count", n_start, 1);
    check("br_retire_count", n_ret, 1);

    // Next instruction; fetch must appear 2 cycles after done. Drop run mid-RUN.
    issue(ALU_CODE, 0);
    tick();
    check("alu_start", fsm_start, 4'b0001);
    check("alu_ctrl", ctrl_out, B0);
    run = 1'b0;
    tick();
    fsm_done = 4'b1000;
    tick();
    check("ignore_unsel_done", insn_retired, 0);
    check("ignore_unsel_ctrl", ctrl_out, B0);
    check("ignore_unsel_busy", busy, 1);
    fsm_done = 4'b0001;
    tick();
    fsm_done = '0;
    check("alu_retire", insn_retired, 1);
    n_fetch = 0;
    tick();
    check("idle_after_retire", busy, 0);
    tick(); tick();
    check("no_fetch_when_idle", n_fetch, 0);

    // Resume, then reset in the middle of RUN.
    issue(ALU_CODE, 0);
    tick();
    tick();
    check("pre_reset_ctrl", ctrl_out, B0);
    reset = 1'b1; run = 1'b0;
    #1;
    check("async_ctrl", ctrl_out, 0);
    check("async_busy", busy, 0);
    check("async_strobes", {fetch_mem_start, fsm_start, insn_retired}, 0);
    tick();
    reset = 1'b0;
    tick();
    check("post_reset_idle", busy, 0);
    check("post_reset_flags", {illegal, timeout}, 0);

    // Code decoding to nothing.
    n_start = 0;
    issue(32'h0, 0);
    tick();
    check("illegal_set", illegal, 1);
    check("illegal_busy", busy, 0);
    check("illegal_ctrl", ctrl_out, 0);
    n_fetch = 0;
    mem_done = 1'b1;
    tick(); tick();
    mem_done = 1'b0;
    tick(); tick();
    check("trap_stays", busy, 0);
    check("trap_no_fetch", n_fetch, 0);
    check("illegal_no_start", n_start, 0);
    check("illegal_sticky", illegal, 1);
    do_reset();
    check("illegal_cleared", illegal, 0);

    // Code claiming two classes.
    issue(BAD2, 0);
    tick();
    check("multi_illegal", illegal, 1);
    check("multi_busy", busy, 0);
    do_reset();

    // Selected FSM never finishes: watchdog after 8 RUN cycles.
    issue(ALU_CODE, 0);
    tick();
    for (int i = 1; i <= TO; i++) begin
      tick();
      check("wd_pending", {timeout, busy}, 2'b01);
    end
    tick();
    check("wd_timeout", timeout, 1);
    check("wd_busy", busy, 0);
    check("wd_ctrl", ctrl_out, 0);
    check("wd_not_illegal", illegal, 0);
    do_reset();
    check("timeout_cleared", timeout, 0);

    // Done on the last watchdog cycle wins.
    issue(ALU_CODE, 0);
    tick();
    for (int i = 1; i <= TO; i++) begin
      tick();
      if (i == TO) fsm_done = 4'b0001;
    end
    tick();
    fsm_done = '0;
    check("tie_retire", insn_retired, 1);
    check("tie_no_timeout", timeout, 0);
    tick();
    check("tie_refetch", fetch_mem_start, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fsm_dispatcher.md
# fsm_dispatcher

Top-level sequencer of the Control Unit. It fetches each instruction, then hands the shared datapath to exactly one execution FSM (ALU, load/store, branch/jump, float) chosen from the opdecoder `code`. It starts that FSM, routes its control bundle to the datapath until the FSM signals `done`, then retires the instruction. It also owns instruction-fetch memory sequencing, illegal-class detection and a hang watchdog.

## Interface
Parameters:
- `N_FSM`, 4, number of execution FSMs, index order fixed by the package.
- `CTRL_W`, 24, width of one FSM's flattened control bundle (loads, selectors, `memory_start`, etc.).
- `TIMEOUT`, 64, maximum cycles in RUN before the watchdog trips.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `run`  in  1  processor enable; sampled only in IDLE and RETIRE.
- `mem_done`  in  1  instruction-memory read complete (one-cycle pulse).
- `code`  in  32  opdecoder output, valid from DECODE onward.
- `fsm_done`  in  N_FSM  per-FSM done pulse.
- `fsm_ctrl`  in  N_FSM*CTRL_W  concatenated control bundles; FSM k occupies bits [k*CTRL_W +: CTRL_W].
- `fetch_mem_start`  out  1  fetch request pulse.
- `load_ir`  out  1  latch instruction register.
- `fsm_start`  out  N_FSM  one-hot start pulse.
- `ctrl_out`  out  CTRL_W  control bundle driven to the datapath.
- `busy`  out  1  high in every state except IDLE and TRAP.
- `insn_retired`  out  1  one-cycle pulse per completed instruction.
- `illegal`  out  1  sticky flag: code did not decode to exactly one FSM.
- `timeout`  out  1  sticky flag: watchdog expired.

## Operation
- States: IDLE, FETCH, FETCH_WAIT, DECODE, START, RUN, RETIRE, TRAP.
- IDLE: go to FETCH if `run`=1.
- FETCH: `fetch_mem_start`=1 for this one cycle; go to FETCH_WAIT.
- FETCH_WAIT: wait for `mem_done`. On the `mem_done` cycle, assert `load_ir`=1 and go to DECODE.
- DECODE: register `sel` = `fsm_class_decode(code)`. If `sel` is zero or not one-hot, go to TRAP and set `illegal`. Otherwise go to START.
- START: `fsm_start`=`sel` for one cycle; clear the watchdog counter; go to RUN.
- RUN: `ctrl_out` = bundle of FSM `sel`. Bundles of unselected FSMs are ignored, and so is their `fsm_done`. When `fsm_done & sel` is nonzero, go to RETIRE.
  - The watchdog counter increments each RUN cycle. When the count reaches TIMEOUT-1 without done, set `timeout` and go to TRAP.
- RETIRE: `insn_retired`=1; go to FETCH if `run`=1, else IDLE.
- TRAP: all strobes 0, `ctrl_out`=0. TRAP is left only by `reset`.
- `ctrl_out` = selected bundle in START and RUN; 0 in every other state. The mux is AND-OR over the one-hot `sel`.
- Simultaneous done and watchdog expiry in the same cycle: done wins, go to RETIRE.
- `run` dropping mid-instruction has no effect until RETIRE.

## Timing
- Reset (async): state=IDLE, `sel`=0, counter=0, `illegal`=`timeout`=0. Every output is 0.
- Registered state, Moore outputs, except `load_ir`, which is combinational on `mem_done` in FETCH_WAIT.
- Overhead per instruction, excluding memory wait and FSM run time: FETCH, DECODE, START, RETIRE = 4 cycles.
- Done-to-next-fetch latency: `fsm_done` seen in cycle t, RETIRE in t+1, FETCH in t+2.
- Counter width is clog2(TIMEOUT). It never wraps, because expiry exits RUN.
- Reset asserted mid-RUN: state goes to IDLE immediately and `ctrl_out` drops to 0 asynchronously. The execution FSMs must be reset by the same `reset`.

## Structure
- Package `cu_pkg` holds:
  - FSM index constants `FSM_ALU`=0, `FSM_LOAD_STORE`=1, `FSM_BRANCH_JUMP`=2, `FSM_FLOAT`=3.
  - `CLASS_MASK_k`: per-FSM `code` bit masks.
  - The state encodings (3-bit) and default `CTRL_W`.
- Sub-module `fsm_class_decode`: combinational, maps `code` to N_FSM one-hot using `CLASS_MASK_k`, and provides a `valid` output.

## Test plan
- Branch instruction, `code` matching only the FSM_BRANCH_JUMP mask, `run`=1, `mem_done` 2 cycles after FETCH, branch FSM done 5 cycles after start -> `fsm_start`=4'b0100 for one cycle, `ctrl_out` equals bundle 2 throughout RUN, `insn_retired` pulses once, FETCH follows 2 cycles after done.
- `code` decoding to 0 -> TRAP, `illegal`=1, `fsm_start` never pulses, `busy`=0. Stays in TRAP until `reset`.
- Selected FSM never asserts done with TIMEOUT=8 -> `timeout`=1 after 8 RUN cycles, `ctrl_out`=0 in TRAP.
- Unselected FSM pulses `fsm_done` and drives a nonzero bundle during RUN -> state and `ctrl_out` are unaffected.
- `run` deasserted during RUN -> after RETIRE, state returns to IDLE with no further `fetch_mem_start`. Reasserting `run` resumes at FETCH.
- `reset` asserted mid-RUN -> all outputs 0 in the same cycle, IDLE after release, flags cleared.
